calc_operand_bank: RTL and testbench
====================================

# calc_operand_bank

Parametrised operand register bank for the hex calculator, the successor to the fixed 4-digit/17-bit operand registers. It sits between the keypad decoder (digit/op/equals/backspace strobes) and the ALU. It holds the first and second operands with digit-count tracking and an entry-full limit, adds clear-entry, and keeps a circular history of results that can be recalled into the active operand.

## Interface
- DIGITS, 4, hex digits per operand; derived W = 4*DIGITS+1 (MSB is the ALU carry/sign bit)
- HIST, 4, result history depth (power of two, ≥2)
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- newhex  in  1  digit strobe
- hexcode  in  4  digit value
- newop  in  1  operator entered; start second operand
- eq  in  1  equals; load ALU result
- bs  in  1  backspace
- ce  in  1  clear active entry
- recall  in  1  load history entry into active operand
- hist_idx  in  clog2(HIST)  history entry to recall, 0 = newest
- answer  in  W  ALU result
- v1curr  out  W  operand 1
- v2curr  out  W  operand 2
- entry_sel  out  1  0 = editing v1, 1 = editing v2
- ndigits  out  clog2(DIGITS+1)  digits in active entry
- full  out  1  ndigits == DIGITS
- hist_count  out  clog2(HIST+1)  valid history entries

## Operation
- States: ENTER1 (active = v1), ENTER2 (active = v2), RESULT (v1 holds result, no active entry).
- At most one action per cycle. Priority: ce > eq > newop > recall > bs > newhex. Lower-priority strobes asserted in the same cycle are dropped. A strobe held high repeats every cycle.
- newhex (ENTER1/2): if !full, active <= {1'b0, active[4*DIGITS-5:0], hexcode}; ndigits++. If full, ignored.
- newhex (RESULT): v1 <= hexcode, ndigits <= 1, go to ENTER1. v2 is unchanged.
- bs (ENTER1/2): active <= {1'b0, active[4*DIGITS-1:4]}; ndigits is decremented, saturating at 0. Ignored in RESULT.
- newop (ENTER1 or RESULT): v2 <= 0, ndigits <= 0, go to ENTER2. In ENTER2: v2 <= 0, ndigits <= 0, stay in ENTER2.
- eq (ENTER2 only): v1 <= answer (all W bits), v2 <= 0, answer is pushed to history, go to RESULT. Ignored in ENTER1 and RESULT.
- ce: the active operand and ndigits are zeroed. In RESULT: v1 <= 0, go to ENTER1.
- recall: if hist_idx < hist_count, the active operand is loaded with history[newest - hist_idx] (full W bits) and ndigits <= DIGITS. Otherwise ignored. In RESULT the value loads into v1 and the state goes to ENTER1.
- History is a circular buffer. On push, the write pointer wraps modulo HIST and hist_count saturates at HIST. When the buffer is full, a push overwrites the oldest entry.
- entry_sel = (state == ENTER2). full is combinational from ndigits.

## Timing
- All state, operands and history update on the rising clock edge. Results are visible the cycle after the strobe.
- reset low immediately forces: v1curr = v2curr = 0, state = ENTER1, entry_sel = 0, ndigits = 0, full = 0, history cleared, hist_count = 0. This applies from any state, mid-entry included.
- answer is sampled in the eq cycle only. Later changes to answer do not affect v1.
- recall reads history combinationally and loads it the same edge. A push and a recall can never occur in the same cycle, because eq has priority.

## Structure
- Package calc_pkg:
  - state enum {ENTER1, ENTER2, RESULT}
  - DIGITS default
  - W derivation function
  - digit shift-in/shift-out helper functions
- Sub-module calc_history contains:
  - HIST x W circular buffer
  - write pointer and count
  - push port
  - read by relative index (0 = newest)
- The top level holds the FSM, the operand registers and the priority decode.

## Test plan
Parameters for all scenarios: DIGITS=4, W=17, HIST=4.
- Reset, then newhex 3, newhex 2 -> v1curr=0x00032, ndigits=2, entry_sel=0.
- newop, then newhex 1 twice, then eq with answer=0x1A -> after newop v2=0x11 and entry_sel=1. After eq v1=0x0001A, v2=0, state RESULT, hist_count=1.
- From RESULT: newhex 5, newhex 5, then bs -> v1 goes 0x5, 0x55, 0x5. Then ce -> v1=0, ndigits=0.
- Digits A,B,C,D,E -> v1=0x0ABCD, full=1, E ignored. Then bs -> 0x00ABC, full=0.
- Five eq cycles with answers 0x10000, 2, 3, 4, 5 -> hist_count=4 and 0x10000 is overwritten. recall idx=3 -> active=2. recall idx=0 -> active=5, ndigits=4.
- Boundary cases:
  - eq+newhex in the same ENTER2 cycle -> eq only.
  - eq in ENTER1 -> no change.
  - reset asserted low between clock edges mid-entry -> all outputs zero at once.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and helpers for the hex calculator operand bank.
// Operand values pass through the helpers at a fixed maximum width and are truncated by callers.
package calc_pkg;

    localparam int unsigned DigitsDefault = 4;
    localparam int unsigned HistDefault   = 4;
    localparam int unsigned MaxDigits     = 16;
    localparam int unsigned MaxW          = 4 * MaxDigits + 1;

    typedef logic [MaxW-1:0] wide_t;

    typedef enum logic [1:0] {
        StEnter1,
        StEnter2,
        StResult
    } calc_state_e;

    typedef enum logic [2:0] {
        ActNone,
        ActCe,
        ActEq,
        ActNewop,
        ActRecall,
        ActBs,
        ActHex
    } calc_act_e;

    // Operand width: DIGITS hex digits plus the ALU carry/sign bit on top.
    function automatic int unsigned calc_w(input int unsigned digits);
        return 4 * digits + 1;
    endfunction

    function automatic wide_t digit_mask(input int unsigned digits);
        return (wide_t'(1) << (4 * digits)) - wide_t'(1);
    endfunction

    // Shift a new least-significant digit in; the top digit and the carry bit fall off.
    function automatic wide_t shift_in(input wide_t val, input logic [3:0] hex,
                                       input int unsigned digits);
        return ((val << 4) | wide_t'(hex)) & digit_mask(digits);
    endfunction

    // Drop the least-significant digit; the carry bit is cleared.
    function automatic wide_t shift_out(input wide_t val, input int unsigned digits);
        return (val & digit_mask(digits)) >> 4;
    endfunction

endpackage

// File: rtl/calc_operand_bank_if.sv
// Keypad/ALU-facing bus of the operand bank: strobes and ALU result in, operands and status out.
interface calc_operand_bank_if #(
    parameter int unsigned Digits = calc_pkg::DigitsDefault,
    parameter int unsigned Hist   = calc_pkg::HistDefault
);
    import calc_pkg::*;

    localparam int unsigned W    = calc_w(Digits);
    localparam int unsigned IdxW = $clog2(Hist);
    localparam int unsigned NdW  = $clog2(Digits + 1);
    localparam int unsigned CntW = $clog2(Hist + 1);

    logic            newhex;
    logic [3:0]      hexcode;
    logic            newop;
    logic            eq;
    logic            bs;
    logic            ce;
    logic            recall;
    logic [IdxW-1:0] hist_idx;
    logic [W-1:0]    answer;

    logic [W-1:0]    v1curr;
    logic [W-1:0]    v2curr;
    logic            entry_sel;
    logic [NdW-1:0]  ndigits;
    logic            full;
    logic [CntW-1:0] hist_count;

    modport master (
        output newhex, hexcode, newop, eq, bs, ce, recall, hist_idx, answer,
        input  v1curr, v2curr, entry_sel, ndigits, full, hist_count
    );

    modport slave (
        input  newhex, hexcode, newop, eq, bs, ce, recall, hist_idx, answer,
        output v1curr, v2curr, entry_sel, ndigits, full, hist_count
    );

endinterface

// File: rtl/calc_history.sv
// Circular result history: one push port, combinational read by age (0 = newest).
module calc_history #(
    parameter int unsigned Width = 17,
    parameter int unsigned Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [Width-1:0]           push_data_i,
    input  logic [$clog2(Depth)-1:0]   rd_idx_i,
    output logic [Width-1:0]           rd_data_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int unsigned IdxW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [IdxW-1:0]  wr_ptr_q;
    logic [CntW-1:0]  count_q;
    logic [IdxW-1:0]  rd_ptr;

    // Depth is a power of two, so pointer arithmetic wraps naturally.
    assign rd_ptr    = wr_ptr_q - IdxW'(1) - rd_idx_i;
    assign rd_data_o = mem_q[rd_ptr];
    assign count_o   = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + IdxW'(1);
            if (count_q != CntW'(Depth)) begin
                count_q <= count_q + CntW'(1);
            end
        end
    end

endmodule

// File: rtl/calc_operand_bank.sv
// Operand register bank for the hex calculator: entry FSM, operand registers and strobe priority.
// Only one strobe acts per cycle; the winner is chosen before the state is considered.
module calc_operand_bank
    import calc_pkg::*;
#(
    parameter int unsigned Digits = DigitsDefault,
    parameter int unsigned Hist   = HistDefault
) (
    input logic                clk_i,
    input logic                rst_ni,
    calc_operand_bank_if.slave bus_io
);

    localparam int unsigned W    = calc_w(Digits);
    localparam int unsigned NdW  = $clog2(Digits + 1);
    localparam int unsigned CntW = $clog2(Hist + 1);

    calc_state_e     state_q;
    logic [W-1:0]    v1_q;
    logic [W-1:0]    v2_q;
    logic [NdW-1:0]  nd_q;

    calc_act_e       act;
    logic            push;
    logic            recall_ok;
    logic            full;
    logic [W-1:0]    active;
    logic [W-1:0]    active_in;
    logic [W-1:0]    active_out;
    logic [W-1:0]    hist_rd;
    logic [CntW-1:0] hist_cnt;

    always_comb begin
        act = ActNone;
        if (bus_io.ce)          act = ActCe;
        else if (bus_io.eq)     act = ActEq;
        else if (bus_io.newop)  act = ActNewop;
        else if (bus_io.recall) act = ActRecall;
        else if (bus_io.bs)     act = ActBs;
        else if (bus_io.newhex) act = ActHex;
    end

    assign push       = (act == ActEq) && (state_q == StEnter2);
    assign recall_ok  = CntW'(bus_io.hist_idx) < hist_cnt;
    assign full       = (nd_q == NdW'(Digits));
    assign active     = (state_q == StEnter2) ? v2_q : v1_q;
    assign active_in  = W'(shift_in(wide_t'(active), bus_io.hexcode, Digits));
    assign active_out = W'(shift_out(wide_t'(active), Digits));

    calc_history #(
        .Width (W),
        .Depth (Hist)
    ) u_hist (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push),
        .push_data_i (bus_io.answer),
        .rd_idx_i    (bus_io.hist_idx),
        .rd_data_o   (hist_rd),
        .count_o     (hist_cnt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StEnter1;
            v1_q    <= '0;
            v2_q    <= '0;
            nd_q    <= '0;
        end else begin
            unique case (act)
                ActCe: begin
                    nd_q <= '0;
                    if (state_q == StEnter2) begin
                        v2_q <= '0;
                    end else begin
                        v1_q    <= '0;
                        state_q <= StEnter1;
                    end
                end
                ActEq: begin
                    if (state_q == StEnter2) begin
                        v1_q    <= bus_io.answer;
                        v2_q    <= '0;
                        nd_q    <= '0;
                        state_q <= StResult;
                    end
                end
                ActNewop: begin
                    v2_q    <= '0;
                    nd_q    <= '0;
                    state_q <= StEnter2;
                end
                ActRecall: begin
                    if (recall_ok) begin
                        nd_q <= NdW'(Digits);
                        if (state_q == StEnter2) begin
                            v2_q <= hist_rd;
                        end else begin
                            v1_q    <= hist_rd;
                            state_q <= StEnter1;
                        end
                    end
                end
                ActBs: begin
                    if (state_q != StResult) begin
                        if (state_q == StEnter2) v2_q <= active_out;
                        else                     v1_q <= active_out;
                        if (nd_q != '0) nd_q <= nd_q - NdW'(1);
                    end
                end
                ActHex: begin
                    if (state_q == StResult) begin
                        v1_q    <= W'(bus_io.hexcode);
                        nd_q    <= NdW'(1);
                        state_q <= StEnter1;
                    end else if (!full) begin
                        if (state_q == StEnter2) v2_q <= active_in;
                        else                     v1_q <= active_in;
                        nd_q <= nd_q + NdW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_io.v1curr     = v1_q;
    assign bus_io.v2curr     = v2_q;
    assign bus_io.entry_sel  = (state_q == StEnter2);
    assign bus_io.ndigits    = nd_q;
    assign bus_io.full       = full;
    assign bus_io.hist_count = hist_cnt;

endmodule

// File: tb/tb_calc_operand_bank.sv
// Directed bench for calc_operand_bank with DIGITS=4, HIST=4 (W=17).
module tb_calc_operand_bank;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    calc_operand_bank_if #(.Digits(4), .Hist(4)) bus ();

    calc_operand_bank #(
        .Digits (4),
        .Hist   (4)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clr();
        bus.newhex = 0; bus.hexcode = 0; bus.newop = 0; bus.eq = 0;
        bus.bs = 0; bus.ce = 0; bus.recall = 0; bus.hist_idx = 0;
    endtask

    // Strobes are set by the caller; sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic do_hex(input logic [3:0] h);
        bus.newhex = 1; bus.hexcode = h; step();
    endtask

    task automatic do_newop();
        bus.newop = 1; step();
    endtask

    task automatic do_eq(input logic [16:0] a);
        bus.answer = a; bus.eq = 1; step();
    endtask

    task automatic do_recall(input logic [1:0] idx);
        bus.recall = 1; bus.hist_idx = idx; step();
    endtask

    task automatic test_reset();
        rst_n = 0;
        #2;
        n_tests++; if (bus.v1curr !== 17'h0) begin n_fail++;
            $display("FAIL reset_v1: got %h want %h", bus.v1curr, 17'h0); end
        n_tests++; if (bus.v2curr !== 17'h0) begin n_fail++;
            $display("FAIL reset_v2: got %h want %h", bus.v2curr, 17'h0); end
        n_tests++; if ({bus.entry_sel, bus.full, bus.ndigits, bus.hist_count} !== 8'h0) begin
            n_fail++; $display("FAIL reset_status: got sel=%b full=%b nd=%0d hc=%0d want all 0",
                bus.entry_sel, bus.full, bus.ndigits, bus.hist_count); end
        rst_n = 1;
    endtask

    task automatic test_entry();
        do_hex(4'h3);
        do_hex(4'h2);
        n_tests++; if (bus.v1curr !== 17'h00032) begin n_fail++;
            $display("FAIL entry_v1: got %h want %h", bus.v1curr, 17'h00032); end
        n_tests++; if (bus.ndigits !== 3'd2 || bus.entry_sel !== 1'b0) begin n_fail++;
            $display("FAIL entry_nd_sel: got nd=%0d sel=%b want 2 0", bus.ndigits, bus.entry_sel); end
    endtask

    task automatic test_operator();
        do_newop();
        do_hex(4'h1);
        do_hex(4'h1);
        n_tests++; if (bus.v2curr !== 17'h00011 || bus.entry_sel !== 1'b1) begin n_fail++;
            $display("FAIL op_v2: got v2=%h sel=%b want 00011 1", bus.v2curr, bus.entry_sel); end
        do_eq(17'h0001A);
        n_tests++; if (bus.v1curr !== 17'h0001A || bus.v2curr !== 17'h0) begin n_fail++;
            $display("FAIL eq_vals: got v1=%h v2=%h want 0001a 00000", bus.v1curr, bus.v2curr); end
        n_tests++; if (bus.entry_sel !== 1'b0 || bus.hist_count !== 3'd1) begin n_fail++;
            $display("FAIL eq_status: got sel=%b hc=%0d want 0 1", bus.entry_sel, bus.hist_count); end
        bus.answer = 17'h01234;
        step();
        n_tests++; if (bus.v1curr !== 17'h0001A) begin n_fail++;
            $display("FAIL answer_sampled: got %h want %h", bus.v1curr, 17'h0001A); end
    endtask

    task automatic test_result_edit();
        do_hex(4'h5);
        n_tests++; if (bus.v1curr !== 17'h00005 || bus.ndigits !== 3'd1) begin n_fail++;
            $display("FAIL res_hex1: got v1=%h nd=%0d want 00005 1", bus.v1curr, bus.ndigits); end
        do_hex(4'h5);
        n_tests++; if (bus.v1curr !== 17'h00055) begin n_fail++;
            $display("FAIL res_hex2: got %h want %h", bus.v1curr, 17'h00055); end
        bus.bs = 1; step();
        n_tests++; if (bus.v1curr !== 17'h00005 || bus.ndigits !== 3'd1) begin n_fail++;
            $display("FAIL res_bs: got v1=%h nd=%0d want 00005 1", bus.v1curr, bus.ndigits); end
        bus.ce = 1; step();
        n_tests++; if (bus.v1curr !== 17'h0 || bus.ndigits !== 3'd0) begin n_fail++;
            $display("FAIL res_ce: got v1=%h nd=%0d want 00000 0", bus.v1curr, bus.ndigits); end
    endtask

    task automatic test_full();
        do_hex(4'hA); do_hex(4'hB); do_hex(4'hC); do_hex(4'hD);
        n_tests++; if (bus.v1curr !== 17'h0ABCD || bus.full !== 1'b1) begin n_fail++;
            $display("FAIL full_set: got v1=%h full=%b want 0abcd 1", bus.v1curr, bus.full); end
        do_hex(4'hE);
        n_tests++; if (bus.v1curr !== 17'h0ABCD || bus.ndigits !== 3'd4) begin n_fail++;
            $display("FAIL full_ignore: got v1=%h nd=%0d want 0abcd 4", bus.v1curr, bus.ndigits); end
        bus.bs = 1; step();
        n_tests++; if (bus.v1curr !== 17'h00ABC || bus.full !== 1'b0 || bus.ndigits !== 3'd3) begin
            n_fail++; $display("FAIL full_bs: got v1=%h full=%b nd=%0d want 00abc 0 3",
                bus.v1curr, bus.full, bus.ndigits); end
    endtask

    task automatic test_eq_ignored();
        do_eq(17'h1FFFF);
        n_tests++; if (bus.v1curr !== 17'h00ABC || bus.ndigits !== 3'd3 ||
                       bus.hist_count !== 3'd1) begin n_fail++;
            $display("FAIL eq_in_enter1: got v1=%h nd=%0d hc=%0d want 00abc 3 1",
                bus.v1curr, bus.ndigits, bus.hist_count); end
    endtask

    task automatic test_eq_priority();
        do_newop();
        do_hex(4'h7);
        bus.newhex = 1; bus.hexcode = 4'h9;
        do_eq(17'h0BEEF);
        n_tests++; if (bus.v1curr !== 17'h0BEEF || bus.v2curr !== 17'h0 ||
                       bus.hist_count !== 3'd2) begin n_fail++;
            $display("FAIL eq_over_hex: got v1=%h v2=%h hc=%0d want 0beef 00000 2",
                bus.v1curr, bus.v2curr, bus.hist_count); end
    endtask

    task automatic test_recall();
        do_recall(2'd2);
        n_tests++; if (bus.v1curr !== 17'h0BEEF || bus.ndigits !== 3'd0) begin n_fail++;
            $display("FAIL recall_range: got v1=%h nd=%0d want 0beef 0", bus.v1curr, bus.ndigits); end
        do_recall(2'd1);
        n_tests++; if (bus.v1curr !== 17'h0001A || bus.ndigits !== 3'd4 || bus.full !== 1'b1) begin
            n_fail++; $display("FAIL recall_old: got v1=%h nd=%0d full=%b want 0001a 4 1",
                bus.v1curr, bus.ndigits, bus.full); end
        do_hex(4'h9);
        n_tests++; if (bus.v1curr !== 17'h0001A) begin n_fail++;
            $display("FAIL recall_then_hex: got %h want %h", bus.v1curr, 17'h0001A); end
        do_newop();
        do_recall(2'd0);
        n_tests++; if (bus.v2curr !== 17'h0BEEF || bus.entry_sel !== 1'b1 ||
                       bus.v1curr !== 17'h0001A) begin n_fail++;
            $display("FAIL recall_v2: got v2=%h sel=%b v1=%h want 0beef 1 0001a",
                bus.v2curr, bus.entry_sel, bus.v1curr); end
    endtask

    task automatic test_history_wrap();
        logic [16:0] answers [5];
        answers = '{17'h10000, 17'h2, 17'h3, 17'h4, 17'h5};
        rst_n = 0; #1; rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            do_newop();
            do_eq(answers[i]);
        end
        n_tests++; if (bus.hist_count !== 3'd4 || bus.v1curr !== 17'h00005) begin n_fail++;
            $display("FAIL wrap_count: got hc=%0d v1=%h want 4 00005", bus.hist_count, bus.v1curr); end
        do_recall(2'd3);
        n_tests++; if (bus.v1curr !== 17'h00002 || bus.ndigits !== 3'd4) begin n_fail++;
            $display("FAIL wrap_oldest: got v1=%h nd=%0d want 00002 4", bus.v1curr, bus.ndigits); end
        do_recall(2'd0);
        n_tests++; if (bus.v1curr !== 17'h00005 || bus.ndigits !== 3'd4) begin n_fail++;
            $display("FAIL wrap_newest: got v1=%h nd=%0d want 00005 4", bus.v1curr, bus.ndigits); end
        bus.ce = 1; step();
        n_tests++; if (bus.v1curr !== 17'h0 || bus.hist_count !== 3'd4) begin n_fail++;
            $display("FAIL ce_keeps_hist: got v1=%h hc=%0d want 00000 4", bus.v1curr, bus.hist_count); end
    endtask

    task automatic test_async_reset();
        do_newop();
        do_hex(4'h3);
        n_tests++; if (bus.v2curr !== 17'h00003 || bus.entry_sel !== 1'b1) begin n_fail++;
            $display("FAIL pre_reset: got v2=%h sel=%b want 00003 1", bus.v2curr, bus.entry_sel); end
        #2;
        rst_n = 0;
        #1;
        n_tests++; if (bus.v1curr !== 17'h0 || bus.v2curr !== 17'h0 || bus.entry_sel !== 1'b0 ||
                       bus.ndigits !== 3'd0 || bus.full !== 1'b0 || bus.hist_count !== 3'd0) begin
            n_fail++; $display("FAIL async_reset: got v1=%h v2=%h sel=%b nd=%0d full=%b hc=%0d",
                bus.v1curr, bus.v2curr, bus.entry_sel, bus.ndigits, bus.full, bus.hist_count); end
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        bus.answer = '0;
        clr();
        test_reset();
        #10;
        test_entry();
        test_operator();
        test_result_edit();
        test_full();
        test_eq_ignored();
        test_eq_priority();
        test_recall();
        test_history_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
